// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master transfer port between two requesters,
// one transfer in flight, fields latched at accept, per-transfer timeout and illegal-select reject.
module apb_req_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STROBE_WIDTH   = 4,
    parameter int SLAVES_NUM     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    r0_valid,
    output logic                    r0_ready,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic [DATA_WIDTH-1:0]   r0_wdata,
    input  logic                    r0_write,
    input  logic [SLAVES_NUM-1:0]   r0_sel,
    input  logic [STROBE_WIDTH-1:0] r0_strb,
    input  logic [2:0]              r0_prot,
    output logic                    r0_done,
    output logic [DATA_WIDTH-1:0]   r0_rdata,
    output logic                    r0_slverr,
    input  logic                    r1_valid,
    output logic                    r1_ready,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic [DATA_WIDTH-1:0]   r1_wdata,
    input  logic                    r1_write,
    input  logic [SLAVES_NUM-1:0]   r1_sel,
    input  logic [STROBE_WIDTH-1:0] r1_strb,
    input  logic [2:0]              r1_prot,
    output logic                    r1_done,
    output logic [DATA_WIDTH-1:0]   r1_rdata,
    output logic                    r1_slverr,
    output logic                    m_Transfer,
    output logic [ADDR_WIDTH-1:0]   m_ADDR,
    output logic [DATA_WIDTH-1:0]   m_DATA,
    output logic                    m_WRITE,
    output logic [SLAVES_NUM-1:0]   m_SEL,
    output logic [STROBE_WIDTH-1:0] m_STROB,
    output logic [2:0]              m_PROT,
    input  logic                    m_done,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_slverr,
    output logic                    grant_id,
    output logic                    timeout_pulse
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, REJECT} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt;
    logic                    last_grant, gnt, acc, legal, timeout_hit, fin, fin_ok, fin_slverr;
    logic [DATA_WIDTH-1:0]   fin_rdata;

    always_comb begin
        gnt         = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
        acc         = RST && state == IDLE && (r0_valid || r1_valid);
        r0_ready    = acc && !gnt;
        r1_ready    = acc && gnt;
        legal       = $onehot(gnt ? r1_sel : r0_sel);
        // abort on the cycle whose count would reach the limit, so the pulse follows TIMEOUT_CYCLES busy cycles
        timeout_hit = (TIMEOUT_CYCLES > 0) && (int'(cnt) + 1 == TIMEOUT_CYCLES);
        m_Transfer  = state == BUSY;
        fin_ok      = state == BUSY && m_done;
        fin         = fin_ok || (state == BUSY && timeout_hit) || state == REJECT;
        fin_rdata   = fin_ok ? m_rdata : '0;
        fin_slverr  = fin_ok ? m_slverr : 1'b1;
        state_nx    = state == IDLE ? (acc ? (legal ? BUSY : REJECT) : IDLE)
                    : state == BUSY ? (fin ? IDLE : BUSY) : IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            m_ADDR        <= '0;
            m_DATA        <= '0;
            m_WRITE       <= 1'b0;
            m_SEL         <= '0;
            m_STROB       <= '0;
            m_PROT        <= '0;
            r0_done       <= 1'b0;
            r0_rdata      <= '0;
            r0_slverr     <= 1'b0;
            r1_done       <= 1'b0;
            r1_rdata      <= '0;
            r1_slverr     <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= (state == BUSY && cnt != '1) ? cnt + 1'b1 : '0;
            r0_done       <= fin && !grant_id;
            r1_done       <= fin && grant_id;
            timeout_pulse <= fin && state == BUSY && !m_done;
            if (acc) begin
                grant_id   <= gnt;
                last_grant <= gnt;
                m_ADDR     <= gnt ? r1_addr : r0_addr;
                m_DATA     <= gnt ? r1_wdata : r0_wdata;
                m_WRITE    <= gnt ? r1_write : r0_write;
                m_SEL      <= gnt ? r1_sel : r0_sel;
                m_STROB    <= gnt ? r1_strb : r0_strb;
                m_PROT     <= gnt ? r1_prot : r0_prot;
            end
            if (fin && !grant_id) begin
                r0_rdata  <= fin_rdata;
                r0_slverr <= fin_slverr;
            end
            if (fin && grant_id) begin
                r1_rdata  <= fin_rdata;
                r1_slverr <= fin_slverr;
            end
        end
    end
endmodule
